mbinit_param_handshake: RTL and testbench

//  MBINIT.PARAM sequencer. Exchanges PARAM configuration req/resp sideband messages with the link partner.

---
 rtl/ucie_sb_pkg.sv | 63 ++++++
 rtl/mbinit_param_handshake_if.sv | 33 +++
 rtl/mbinit_param_handshake_sb_tx_hold.sv | 62 ++++++
 rtl/mbinit_param_handshake.sv | 196 +++++++++++++++++++
 tb/tb_mbinit_param_handshake.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ucie_sb_pkg.sv
// Sideband message IDs, PARAM payload layout and sequencer states
// shared by the MBINIT.PARAM handshake block.
package ucie_sb_pkg;

  localparam logic [3:0] MSG_PARAM_REQ  = 4'h5;
  localparam logic [3:0] MSG_PARAM_RESP = 4'h6;

  localparam int SB_DATA_W     = 16;
  localparam int RATE_W        = 3;
  localparam int VS_W          = 5;

  localparam int REQ_VS_LSB    = 0;
  localparam int REQ_RATE_LSB  = 5;
  localparam int REQ_CM_BIT    = 8;
  localparam int REQ_PC_BIT    = 9;

  localparam int RESP_RATE_LSB = 5;
  localparam int RESP_OK_BIT   = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_REQ,
    ST_WAIT_REQ,
    ST_CHECK,
    ST_SEND_RESP,
    ST_WAIT_RESP,
    ST_DONE,
    ST_ERROR
  } param_state_e;

  function automatic logic [SB_DATA_W-1:0] pack_req(
    input logic [VS_W-1:0]   vs,
    input logic [RATE_W-1:0] rate,
    input logic              cm,
    input logic              pc
  );
    logic [SB_DATA_W-1:0] p;
    p = '0;
    p[REQ_VS_LSB +: VS_W]     = vs;
    p[REQ_RATE_LSB +: RATE_W] = rate;
    p[REQ_CM_BIT]             = cm;
    p[REQ_PC_BIT]             = pc;
    return p;
  endfunction

  function automatic logic [SB_DATA_W-1:0] pack_resp(
    input logic              ok,
    input logic [RATE_W-1:0] rate
  );
    logic [SB_DATA_W-1:0] p;
    p = '0;
    p[RESP_RATE_LSB +: RATE_W] = ok ? rate : '0;
    p[RESP_OK_BIT]             = ok;
    return p;
  endfunction

  // States in which the timeout runs and partner messages are captured
  function automatic logic is_active(input param_state_e s);
    return s inside {ST_SEND_REQ, ST_WAIT_REQ, ST_CHECK,
                     ST_SEND_RESP, ST_WAIT_RESP};
  endfunction

endpackage

// File: rtl/mbinit_param_handshake_if.sv
// Sideband RX strobe and TX request/busy handshake between the
// PARAM sequencer (master) and the sideband link (slave).
interface mbinit_param_handshake_if;

  logic        i_SB_Valid;
  logic [3:0]  i_SB_MsgID;
  logic [15:0] i_SB_Data;
  logic        i_SB_Busy;
  logic        o_SB_Send;
  logic [3:0]  o_SB_MsgID;
  logic [15:0] o_SB_Data;

  modport master (
    input  i_SB_Valid,
    input  i_SB_MsgID,
    input  i_SB_Data,
    input  i_SB_Busy,
    output o_SB_Send,
    output o_SB_MsgID,
    output o_SB_Data
  );

  modport slave (
    output i_SB_Valid,
    output i_SB_MsgID,
    output i_SB_Data,
    output i_SB_Busy,
    input  o_SB_Send,
    input  o_SB_MsgID,
    input  o_SB_Data
  );

endinterface

// File: rtl/mbinit_param_handshake_sb_tx_hold.sv
// Holds a sideband TX request (send/ID/data) stable until the link
// accepts it with busy low; flush drops any pending request.
module sb_tx_hold
  import ucie_sb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 load,
  input  logic [3:0]           ld_id,
  input  logic [SB_DATA_W-1:0] ld_data,
  input  logic                 busy,
  output logic                 send,
  output logic [3:0]           id,
  output logic [SB_DATA_W-1:0] data,
  output logic                 accepted
);

  logic                 send_q, send_d;
  logic [3:0]           id_q, id_d;
  logic [SB_DATA_W-1:0] data_q, data_d;

  assign accepted = send_q & ~busy;

  always_comb begin
    send_d = send_q;
    id_d   = id_q;
    data_d = data_q;
    if (accepted) begin
      send_d = 1'b0;
      id_d   = '0;
      data_d = '0;
    end
    if (load) begin
      send_d = 1'b1;
      id_d   = ld_id;
      data_d = ld_data;
    end
    if (flush) begin
      send_d = 1'b0;
      id_d   = '0;
      data_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      send_q <= 1'b0;
      id_q   <= '0;
      data_q <= '0;
    end else begin
      send_q <= send_d;
      id_q   <= id_d;
      data_q <= data_d;
    end
  end

  assign send = send_q;
  assign id   = id_q;
  assign data = data_q;

endmodule

// File: rtl/mbinit_param_handshake.sv
// MBINIT.PARAM sequencer: trades PARAM req/resp with the partner,
// latches partner parameters for the checker, reports done/error.
module mbinit_param_handshake
  import ucie_sb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 8000,
  parameter int CNT_W          = 14
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  i_Enable,
  input  logic [VS_W-1:0]       i_TX_VoltageSwing,
  input  logic [RATE_W-1:0]     i_TX_MaxDataRate,
  input  logic                  i_TX_ClockMode,
  input  logic                  i_TX_PhaseClock,
  mbinit_param_handshake_if.master sb,
  output logic                  o_Enable_Checker,
  output logic [RATE_W-1:0]     o_RX_MaxDataRate,
  output logic                  o_RX_ClockMode,
  output logic                  o_RX_PhaseClock,
  input  logic                  i_Finish_Checker,
  input  logic                  i_Successful_Param,
  output logic [RATE_W-1:0]     o_Final_MaxDataRate,
  output logic                  o_Done,
  output logic                  o_Error
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  param_state_e         state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 req_seen_q, req_seen_d;
  logic                 resp_seen_q, resp_seen_d;
  logic                 resp_ok_q, resp_ok_d;
  logic [RATE_W-1:0]    resp_rate_q, resp_rate_d;
  logic                 chk_ok_q, chk_ok_d;
  logic [RATE_W-1:0]    rx_rate_q, rx_rate_d;
  logic                 rx_cm_q, rx_cm_d;
  logic                 rx_pc_q, rx_pc_d;

  logic                 active;
  logic                 tx_load;
  logic                 tx_flush;
  logic [3:0]           tx_id;
  logic [SB_DATA_W-1:0] tx_data;
  logic                 tx_accepted;
  logic                 unused_bits;

  assign active = is_active(state_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_seen_d  = req_seen_q;
    resp_seen_d = resp_seen_q;
    resp_ok_d   = resp_ok_q;
    resp_rate_d = resp_rate_q;
    chk_ok_d    = chk_ok_q;
    rx_rate_d   = rx_rate_q;
    rx_cm_d     = rx_cm_q;
    rx_pc_d     = rx_pc_q;
    tx_load     = 1'b0;
    tx_flush    = 1'b0;
    tx_id       = '0;
    tx_data     = '0;

    if (active) cnt_d = cnt_q + CNT_W'(1);

    // Partner messages may arrive in any order while active
    if (active && sb.i_SB_Valid) begin
      if (sb.i_SB_MsgID == MSG_PARAM_REQ) begin
        rx_rate_d  = sb.i_SB_Data[REQ_RATE_LSB +: RATE_W];
        rx_cm_d    = sb.i_SB_Data[REQ_CM_BIT];
        rx_pc_d    = sb.i_SB_Data[REQ_PC_BIT];
        req_seen_d = 1'b1;
      end else if (sb.i_SB_MsgID == MSG_PARAM_RESP) begin
        resp_ok_d   = sb.i_SB_Data[RESP_OK_BIT];
        resp_rate_d = sb.i_SB_Data[RESP_RATE_LSB +: RATE_W];
        resp_seen_d = 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (i_Enable) begin
          state_d = ST_SEND_REQ;
          cnt_d   = '0;
          tx_load = 1'b1;
          tx_id   = MSG_PARAM_REQ;
          tx_data = pack_req(i_TX_VoltageSwing, i_TX_MaxDataRate,
                             i_TX_ClockMode, i_TX_PhaseClock);
        end
      end
      ST_SEND_REQ: begin
        if (tx_accepted) state_d = ST_WAIT_REQ;
      end
      ST_WAIT_REQ: begin
        if (req_seen_q) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (i_Finish_Checker) begin
          chk_ok_d = i_Successful_Param;
          state_d  = ST_SEND_RESP;
          tx_load  = 1'b1;
          tx_id    = MSG_PARAM_RESP;
          tx_data  = pack_resp(i_Successful_Param, rx_rate_q);
        end
      end
      ST_SEND_RESP: begin
        if (tx_accepted)
          state_d = chk_ok_q ? ST_WAIT_RESP : ST_ERROR;
      end
      ST_WAIT_RESP: begin
        if (resp_seen_q)
          state_d = resp_ok_q ? ST_DONE : ST_ERROR;
      end
      ST_DONE: ;
      ST_ERROR: ;
    endcase

    // Timeout overrides whatever the state wanted this cycle
    if (active && cnt_q == TO_LAST) begin
      state_d  = ST_ERROR;
      tx_load  = 1'b0;
      tx_flush = 1'b1;
    end

    if (!i_Enable) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      req_seen_d  = 1'b0;
      resp_seen_d = 1'b0;
      resp_ok_d   = 1'b0;
      resp_rate_d = '0;
      chk_ok_d    = 1'b0;
      rx_rate_d   = '0;
      rx_cm_d     = 1'b0;
      rx_pc_d     = 1'b0;
      tx_load     = 1'b0;
      tx_flush    = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_seen_q  <= 1'b0;
      resp_seen_q <= 1'b0;
      resp_ok_q   <= 1'b0;
      resp_rate_q <= '0;
      chk_ok_q    <= 1'b0;
      rx_rate_q   <= '0;
      rx_cm_q     <= 1'b0;
      rx_pc_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_seen_q  <= req_seen_d;
      resp_seen_q <= resp_seen_d;
      resp_ok_q   <= resp_ok_d;
      resp_rate_q <= resp_rate_d;
      chk_ok_q    <= chk_ok_d;
      rx_rate_q   <= rx_rate_d;
      rx_cm_q     <= rx_cm_d;
      rx_pc_q     <= rx_pc_d;
    end
  end

  sb_tx_hold u_tx (
    .clk      (CLK),
    .rst      (rst),
    .flush    (tx_flush),
    .load     (tx_load),
    .ld_id    (tx_id),
    .ld_data  (tx_data),
    .busy     (sb.i_SB_Busy),
    .send     (sb.o_SB_Send),
    .id       (sb.o_SB_MsgID),
    .data     (sb.o_SB_Data),
    .accepted (tx_accepted)
  );

  // Payload fields with no consumer in this block
  assign unused_bits = ^{sb.i_SB_Data[14:10],
                         sb.i_SB_Data[4:0], resp_rate_q};

  assign o_Enable_Checker    = (state_q == ST_CHECK);
  assign o_RX_MaxDataRate    = rx_rate_q;
  assign o_RX_ClockMode      = rx_cm_q;
  assign o_RX_PhaseClock     = rx_pc_q;
  assign o_Done              = (state_q == ST_DONE);
  assign o_Error             = (state_q == ST_ERROR);
  assign o_Final_MaxDataRate = o_Done ? rx_rate_q : '0;

endmodule

// File: tb/tb_mbinit_param_handshake.sv
// Directed bench for the MBINIT.PARAM sequencer with a behavioural
// parameter checker and a sideband TX capture queue.
module tb_mbinit_param_handshake;

  logic        CLK = 1'b0;
  logic        rst;
  logic        en;
  logic [4:0]  vs;
  logic [2:0]  rate;
  logic        cm;
  logic        pc;
  logic        chk_en;
  logic [2:0]  rx_rate;
  logic        rx_cm;
  logic        rx_pc;
  logic        fin;
  logic        succ;
  logic [2:0]  final_rate;
  logic        done;
  logic        err;
  logic        chk_hold;

  int tests = 0;
  int fails = 0;

  logic [3:0]  sent_id[$];
  logic [15:0] sent_data[$];

  mbinit_param_handshake_if sb_if ();

  mbinit_param_handshake #(
    .TIMEOUT_CYCLES (50),
    .CNT_W          (6)
  ) dut (
    .CLK                 (CLK),
    .rst                 (rst),
    .i_Enable            (en),
    .i_TX_VoltageSwing   (vs),
    .i_TX_MaxDataRate    (rate),
    .i_TX_ClockMode      (cm),
    .i_TX_PhaseClock     (pc),
    .sb                  (sb_if),
    .o_Enable_Checker    (chk_en),
    .o_RX_MaxDataRate    (rx_rate),
    .o_RX_ClockMode      (rx_cm),
    .o_RX_PhaseClock     (rx_pc),
    .i_Finish_Checker    (fin),
    .i_Successful_Param  (succ),
    .o_Final_MaxDataRate (final_rate),
    .o_Done              (done),
    .o_Error             (err)
  );

  always #5 CLK = ~CLK;

  // Combinational checker model: partner must match local values
  assign fin  = chk_en & ~chk_hold;
  assign succ = (rx_rate == rate) && (rx_cm == cm) && (rx_pc == pc);

  always @(negedge CLK) begin
    if (sb_if.o_SB_Send && !sb_if.i_SB_Busy) begin
      sent_id.push_back(sb_if.o_SB_MsgID);
      sent_data.push_back(sb_if.o_SB_Data);
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic partner(input logic [3:0] id, input logic [15:0] d);
    sb_if.i_SB_Valid = 1'b1;
    sb_if.i_SB_MsgID = id;
    sb_if.i_SB_Data  = d;
    tick();
    sb_if.i_SB_Valid = 1'b0;
    sb_if.i_SB_MsgID = 4'h0;
    sb_if.i_SB_Data  = 16'h0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    tests++;
    if (done !== 1'b0 || err !== 1'b0) begin
      $display("FAIL reset_status: done=%b err=%b want 0 0", done, err);
      fails++;
    end
    tests++;
    if (chk_en !== 1'b0 || final_rate !== 3'd0) begin
      $display("FAIL reset_chk: en=%b final=%0d want 0 0",
               chk_en, final_rate);
      fails++;
    end
    tests++;
    if ({rx_rate, rx_cm, rx_pc} !== 5'd0) begin
      $display("FAIL reset_rx: got %h want 0", {rx_rate, rx_cm, rx_pc});
      fails++;
    end
    tests++;
    if (sb_if.o_SB_Send !== 1'b0 || sb_if.o_SB_MsgID !== 4'h0 ||
        sb_if.o_SB_Data !== 16'h0) begin
      $display("FAIL reset_tx: send=%b id=%h data=%h want 0",
               sb_if.o_SB_Send, sb_if.o_SB_MsgID, sb_if.o_SB_Data);
      fails++;
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_match;
    sent_id.delete();
    sent_data.delete();
    en = 1'b1;
    tick();
    tests++;
    if (sb_if.o_SB_Send !== 1'b1 || sb_if.o_SB_MsgID !== 4'h5 ||
        sb_if.o_SB_Data !== 16'h028A) begin
      $display("FAIL match_req: send=%b id=%h data=%h want 1 5 028a",
               sb_if.o_SB_Send, sb_if.o_SB_MsgID, sb_if.o_SB_Data);
      fails++;
    end
    partner(4'h5, 16'h028A);
    partner(4'h6, 16'h8080);
    for (int i = 0; i < 10; i++) begin
      if (done) break;
      tick();
    end
    tests++;
    if (done !== 1'b1 || err !== 1'b0) begin
      $display("FAIL match_done: done=%b err=%b want 1 0", done, err);
      fails++;
    end
    tests++;
    if (final_rate !== 3'd4 || rx_pc !== 1'b1 || rx_cm !== 1'b0) begin
      $display("FAIL match_rate: final=%0d pc=%b cm=%b want 4 1 0",
               final_rate, rx_pc, rx_cm);
      fails++;
    end
    tests++;
    if (sent_data.size() != 2 || sent_id[1] !== 4'h6 ||
        sent_data[1] !== 16'h8080) begin
      $display("FAIL match_resp: n=%0d last=%h want 2 8080",
               sent_data.size(), sent_data[sent_data.size()-1]);
      fails++;
    end
    en = 1'b0;
    tick();
    tests++;
    if (done !== 1'b0 || rx_rate !== 3'd0 || final_rate !== 3'd0) begin
      $display("FAIL match_disable: done=%b rx=%0d final=%0d want 0",
               done, rx_rate, final_rate);
      fails++;
    end
  endtask

  task automatic test_mismatch;
    sent_id.delete();
    sent_data.delete();
    en = 1'b1;
    tick();
    partner(4'h5, 16'h024A);
    for (int i = 0; i < 10; i++) begin
      if (err) break;
      tick();
    end
    tests++;
    if (err !== 1'b1 || done !== 1'b0) begin
      $display("FAIL mismatch_err: err=%b done=%b want 1 0", err, done);
      fails++;
    end
    tests++;
    if (sent_data.size() != 2 || sent_id[1] !== 4'h6 ||
        sent_data[1] !== 16'h0000) begin
      $display("FAIL mismatch_resp: n=%0d last=%h want 2 0000",
               sent_data.size(), sent_data[sent_data.size()-1]);
      fails++;
    end
    tests++;
    if (rx_rate !== 3'd2 || final_rate !== 3'd0) begin
      $display("FAIL mismatch_rx: rx=%0d final=%0d want 2 0",
               rx_rate, final_rate);
      fails++;
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_early_arrival;
    sent_id.delete();
    sent_data.delete();
    sb_if.i_SB_Busy = 1'b1;
    en = 1'b1;
    tick();
    partner(4'h5, 16'h028A);
    partner(4'h6, 16'h8080);
    repeat (8) tick();
    tests++;
    if (sb_if.o_SB_Send !== 1'b1 || sb_if.o_SB_Data !== 16'h028A ||
        sb_if.o_SB_MsgID !== 4'h5) begin
      $display("FAIL early_hold: send=%b id=%h data=%h want 1 5 028a",
               sb_if.o_SB_Send, sb_if.o_SB_MsgID, sb_if.o_SB_Data);
      fails++;
    end
    sb_if.i_SB_Busy = 1'b0;
    repeat (4) tick();
    tests++;
    if (done !== 1'b0) begin
      $display("FAIL early_not_yet: done=%b want 0", done);
      fails++;
    end
    tick();
    tests++;
    if (done !== 1'b1 || final_rate !== 3'd4) begin
      $display("FAIL early_done: done=%b final=%0d want 1 4",
               done, final_rate);
      fails++;
    end
    tests++;
    if (sent_data.size() != 2) begin
      $display("FAIL early_count: sent=%0d want 2", sent_data.size());
      fails++;
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_timeout;
    sb_if.i_SB_Busy = 1'b0;
    en = 1'b1;
    tick();
    repeat (49) tick();
    tests++;
    if (err !== 1'b0) begin
      $display("FAIL timeout_early: err=%b want 0 at cycle 49", err);
      fails++;
    end
    tick();
    tests++;
    if (err !== 1'b1 || done !== 1'b0) begin
      $display("FAIL timeout_fire: err=%b done=%b want 1 0", err, done);
      fails++;
    end
    en = 1'b0;
    tick();
    tests++;
    if (err !== 1'b0) begin
      $display("FAIL timeout_clear: err=%b want 0", err);
      fails++;
    end
  endtask

  task automatic test_reenable;
    sent_id.delete();
    sent_data.delete();
    en = 1'b1;
    tick();
    partner(4'h5, 16'h028A);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sent_data.size() >= 2) break;
    end
    tests++;
    if (done !== 1'b0 || err !== 1'b0 || sent_data.size() != 2) begin
      $display("FAIL reen_wait: done=%b err=%b sent=%0d want 0 0 2",
               done, err, sent_data.size());
      fails++;
    end
    sb_if.i_SB_Valid = 1'b1;
    sb_if.i_SB_MsgID = 4'h6;
    sb_if.i_SB_Data  = 16'h8080;
    en = 1'b0;
    tick();
    sb_if.i_SB_Valid = 1'b0;
    sb_if.i_SB_MsgID = 4'h0;
    sb_if.i_SB_Data  = 16'h0;
    tests++;
    if (done !== 1'b0 || rx_rate !== 3'd0 || sb_if.o_SB_Send !== 1'b0) begin
      $display("FAIL reen_idle: done=%b rx=%0d send=%b want 0 0 0",
               done, rx_rate, sb_if.o_SB_Send);
      fails++;
    end
    sent_id.delete();
    sent_data.delete();
    en = 1'b1;
    tick();
    tests++;
    if (sb_if.o_SB_Send !== 1'b1 || sb_if.o_SB_MsgID !== 4'h5) begin
      $display("FAIL reen_req: send=%b id=%h want 1 5",
               sb_if.o_SB_Send, sb_if.o_SB_MsgID);
      fails++;
    end
    partner(4'h5, 16'h028A);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sent_data.size() >= 2) break;
    end
    repeat (3) tick();
    tests++;
    if (done !== 1'b0 || err !== 1'b0) begin
      $display("FAIL reen_stale: done=%b err=%b want 0 0", done, err);
      fails++;
    end
    partner(4'h6, 16'h8080);
    tick();
    tests++;
    if (done !== 1'b1 || final_rate !== 3'd4) begin
      $display("FAIL reen_done: done=%b final=%0d want 1 4",
               done, final_rate);
      fails++;
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_rst_in_check;
    chk_hold = 1'b1;
    en = 1'b1;
    tick();
    partner(4'h5, 16'h028A);
    for (int i = 0; i < 10; i++) begin
      if (chk_en) break;
      tick();
    end
    repeat (2) tick();
    tests++;
    if (chk_en !== 1'b1) begin
      $display("FAIL rst_hold_check: chk_en=%b want 1", chk_en);
      fails++;
    end
    rst = 1'b1;
    tick();
    tests++;
    if (chk_en !== 1'b0 || {rx_rate, rx_cm, rx_pc} !== 5'd0 ||
        done !== 1'b0 || err !== 1'b0 || sb_if.o_SB_Send !== 1'b0) begin
      $display("FAIL rst_outputs: chk=%b rx=%h done=%b err=%b send=%b want 0",
               chk_en, {rx_rate, rx_cm, rx_pc}, done, err, sb_if.o_SB_Send);
      fails++;
    end
    en = 1'b0;
    chk_hold = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    vs = 5'h0A;
    rate = 3'd4;
    cm = 1'b0;
    pc = 1'b1;
    chk_hold = 1'b0;
    sb_if.i_SB_Valid = 1'b0;
    sb_if.i_SB_MsgID = 4'h0;
    sb_if.i_SB_Data  = 16'h0;
    sb_if.i_SB_Busy  = 1'b0;
    test_reset();
    test_match();
    test_mismatch();
    test_early_arrival();
    test_timeout();
    test_reenable();
    test_rst_in_check();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
